mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single synchronous 64 KiB memory port between the 6502 core (CPU) and a DMA master.
//  Per-cycle arbitration: CPU has priority, but a DMA master that already holds the bus keeps it
//  for a bounded burst. Sits between proc/DMA and the memory macro; 1-cycle read latency.
// PARAMETERS
//  ADDR_W        16  address width (both masters and memory)
//  DATA_W         8  data width
//  DMA_MAX_BURST  8  max consecutive DMA grants while CPU is waiting (1..255)
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  resetn      in   1       reset, synchronous, active-low
//  cpu_req     in   1       CPU requests an access this cycle
//  cpu_we      in   1       1=write, 0=read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_gnt     out  1       CPU access accepted this cycle (combinational)
//  cpu_rvalid  out  1       mem_rdata is CPU read data (cycle after granted read)
//  dma_req/dma_we/dma_addr/dma_wdata/dma_gnt/dma_rvalid   same as cpu_* for DMA master
//  rdata       out  DATA_W  read data, broadcast to both masters; qualified by *_rvalid
//  mem_en      out  1       memory access strobe
//  mem_we      out  1       memory write enable
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data, valid 1 cycle after mem_en & ~mem_we
// BEHAVIOUR
//  Access occurs in a cycle iff req & gnt; a master holds addr/we/wdata stable until granted.
//  State reg owner: IDLE / CPU / DMA = master granted in previous cycle (IDLE: none).
//  Counter wait_cnt (8 b): consecutive cycles in which cpu_req=1 and DMA was granted.
//  Grant equations (all gated low while resetn=0):
//   dma_gnt = dma_req & (~cpu_req | (owner==DMA & wait_cnt < DMA_MAX_BURST))
//   cpu_gnt = cpu_req & ~dma_gnt    -> never both high; never grant without req.
//  Transitions each edge: owner <= DMA if dma_gnt, CPU if cpu_gnt, else IDLE.
//  wait_cnt <= wait_cnt+1 if cpu_req & dma_gnt; <= 0 if cpu_gnt or ~cpu_req.
//   At wait_cnt==DMA_MAX_BURST with cpu_req=1: CPU wins; DMA must re-win arbitration afterwards.
//   Guarantee: CPU waits at most DMA_MAX_BURST cycles. DMA fresh request loses to a CPU request.
//  Memory port: mem_en = cpu_gnt|dma_gnt; addr/we/wdata muxed from granted master; zeros when idle.
//  Read return: cpu_rvalid <= cpu_gnt & ~cpu_we; dma_rvalid <= dma_gnt & ~dma_we (registered).
//   rdata = mem_rdata (pass-through). Back-to-back reads from alternating masters allowed;
//   each rvalid pulses exactly one cycle after its grant.
//  Simultaneous req, both idle: CPU granted. Single requester: granted same cycle, no bubble.
//  Reset (sync, resetn=0): owner=IDLE, wait_cnt=0, cpu_rvalid=dma_rvalid=0, all gnt/mem_* = 0.
//   Reset mid-burst or with read in flight: read data dropped, no rvalid after reset release.
//  wait_cnt never exceeds DMA_MAX_BURST (no wrap).
// STRUCTURE
//  Shared header bus.vh: owner encoding (OWN_IDLE=2'd0, OWN_CPU=2'd1, OWN_DMA=2'd2), ADDR_W/DATA_W defaults.
//  Single module; no sub-module needed (port mux is a few assigns). Est. ~150 lines RTL.
// TESTING
//  1 resetn=0 with both req=1 -> gnt=0, mem_en=0, rvalid=0; release -> CPU granted first cycle.
//  2 CPU read 0x1234 alone, mem returns 0xA5 -> cpu_gnt same cycle, cpu_rvalid=1, rdata=0xA5 next cycle.
//  3 DMA streams 20 reads from 0x0200, CPU reqs at cycle 3 (DMA_MAX_BURST=8) -> DMA keeps 8 cycles,
//    CPU granted cycle 11, DMA resumes cycle 12 if CPU drops req.
//  4 Both req from idle, CPU write 0x42 to 0x00FF -> cpu_gnt=1, dma_gnt=0, mem_we=1, mem_wdata=0x42.
//  5 Alternating CPU read / DMA read each cycle -> rvalid pulses track grant owner 1 cycle later.
//  6 resetn pulsed low 1 cycle during DMA burst with read in flight -> no dma_rvalid, wait_cnt=0, owner=IDLE.
//  Assertions: never cpu_gnt&dma_gnt; CPU wait <= DMA_MAX_BURST; gnt implies req.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory-port arbiter.
package mem_arbiter_pkg;

    // Master that was granted the port in the previous cycle
    typedef enum logic [1:0] {
        OwnIdle = 2'd0,
        OwnCpu  = 2'd1,
        OwnDma  = 2'd2
    } owner_e;

    localparam int unsigned AddrWDefault       = 16;
    localparam int unsigned DataWDefault       = 8;
    localparam int unsigned DmaMaxBurstDefault = 8;
    localparam int unsigned WaitCntW           = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one synchronous memory port between the CPU and a DMA master.
// CPU has priority, except that a DMA master already holding the port may keep it for up to
// DMA_MAX_BURST cycles while the CPU waits. Reads return one cycle after the grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = AddrWDefault,
    parameter int unsigned DATA_W        = DataWDefault,
    parameter int unsigned DMA_MAX_BURST = DmaMaxBurstDefault
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WaitCntW-1:0] MaxBurst = WaitCntW'(DMA_MAX_BURST);

    owner_e              owner_q, owner_d;
    logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;
    logic                cpu_rvalid_q, cpu_rvalid_d;
    logic                dma_rvalid_q, dma_rvalid_d;
    logic                dma_keeps;

    // Grant decision: DMA only beats a requesting CPU while continuing its own bounded burst
    always_comb begin
        dma_keeps = (owner_q == OwnDma) && (wait_cnt_q < MaxBurst);
        dma_gnt   = resetn & dma_req & (~cpu_req | dma_keeps);
        cpu_gnt   = resetn & cpu_req & ~dma_gnt;
    end

    // Next owner, CPU starvation counter and read-return strobes
    always_comb begin
        owner_d = OwnIdle;
        if (dma_gnt) begin
            owner_d = OwnDma;
        end else if (cpu_gnt) begin
            owner_d = OwnCpu;
        end

        wait_cnt_d = '0;
        if (cpu_req && dma_gnt) begin
            // Saturate so the count can never wrap back below the burst limit
            wait_cnt_d = (wait_cnt_q == MaxBurst) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        cpu_rvalid_d = cpu_gnt & ~cpu_we;
        dma_rvalid_d = dma_gnt & ~dma_we;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner_q      <= OwnIdle;
            wait_cnt_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    // Memory port mux: follows the granted master, drives zeros when idle
    always_comb begin
        mem_en    = cpu_gnt | dma_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    // Read data is shared; a read in flight while reset is asserted is dropped
    assign rdata      = mem_rdata;
    assign cpu_rvalid = cpu_rvalid_q & resetn;
    assign dma_rvalid = dma_rvalid_q & resetn;

    // Arbitration safety properties
    a_onehot_gnt : assert property (@(posedge clk) disable iff (!resetn)
        !(cpu_gnt && dma_gnt));
    a_gnt_has_req : assert property (@(posedge clk) disable iff (!resetn)
        (!cpu_gnt || cpu_req) && (!dma_gnt || dma_req));
    a_wait_bounded : assert property (@(posedge clk) disable iff (!resetn)
        wait_cnt_q <= MaxBurst);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic checked against
// a behavioural arbitration/memory model; a separate monitor checks read returns.
module tb_mem_arbiter;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 8;
    localparam int unsigned MAX = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .DMA_MAX_BURST (MAX)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Power-on memory contents; 0x1234 holds 0xA5
    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h83;
    endfunction

    // Memory macro driven by the DUT's port
    logic [7:0] mem   [0:65535];
    bit         mem_v [0:65535];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr]   <= mem_wdata;
            mem_v[mem_addr] <= 1'b1;
        end else if (mem_en) begin
            mem_rdata <= mem_v[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
        end
    end

    // Reference copy of memory updated by the model's expected accesses
    logic [7:0] shadow   [0:65535];
    bit         shadow_v [0:65535];
    function automatic logic [7:0] shadow_rd(input logic [15:0] a);
        return shadow_v[a] ? shadow[a] : init_val(a);
    endfunction

    typedef struct {
        int         due;
        logic [7:0] data;
    } rd_t;
    rd_t cpu_q[$];
    rd_t dma_q[$];

    // Master state: a request is held until granted
    logic        c_pend = 0, c_w = 0, d_pend = 0, d_w = 0;
    logic [15:0] c_a = '0, d_a = '0;
    logic [7:0]  c_wd = '0, d_wd = '0;
    int          cpu_pct = 0, dma_pct = 0;
    bit          dma_stream = 0;
    int          stream_left = 0;
    logic [15:0] stream_ptr = '0;
    logic        rst_drv = 1'b0;

    // Model: whether DMA held the port last cycle, and how long the CPU has waited behind it
    bit dma_had = 0;
    int cpu_waited = 0;
    int dut_wait = 0;

    task automatic gen();
        if (!c_pend && $urandom_range(0, 99) < cpu_pct) begin
            c_pend = 1; c_w = ($urandom_range(0, 2) == 0);
            c_a = 16'($urandom_range(0, 63)); c_wd = 8'($urandom);
        end
        if (!d_pend) begin
            if (dma_stream && stream_left > 0) begin
                d_pend = 1; d_w = 0; d_a = stream_ptr;
                stream_ptr++; stream_left--;
            end else if ($urandom_range(0, 99) < dma_pct) begin
                d_pend = 1; d_w = ($urandom_range(0, 2) == 0);
                d_a = 16'($urandom_range(0, 63)); d_wd = 8'($urandom);
            end
        end
    endtask

    task automatic check_cycle();
        logic ec, ed;
        if (!resetn) begin
            ec = 0; ed = 0;
        end else begin
            // DMA keeps the port only if it had it and the CPU has not yet waited a full burst
            ed = d_pend && (!c_pend || (dma_had && cpu_waited < MAX));
            ec = c_pend && !ed;
        end
        chk("cpu_gnt", cpu_gnt, ec);
        chk("dma_gnt", dma_gnt, ed);
        chk("gnt_exclusive_and_requested",
            (cpu_gnt & dma_gnt) | (cpu_gnt & ~cpu_req) | (dma_gnt & ~dma_req), 0);
        chk("mem_en", mem_en, ec | ed);
        if (ec) begin
            chk("mem_we_cpu", mem_we, c_w);
            chk("mem_addr_cpu", mem_addr, c_a);
            chk("mem_wdata_cpu", mem_wdata, c_wd);
            if (c_w) begin shadow[c_a] = c_wd; shadow_v[c_a] = 1; end
            else cpu_q.push_back('{due: cyc + 1, data: shadow_rd(c_a)});
        end else if (ed) begin
            chk("mem_we_dma", mem_we, d_w);
            chk("mem_addr_dma", mem_addr, d_a);
            chk("mem_wdata_dma", mem_wdata, d_wd);
            if (d_w) begin shadow[d_a] = d_wd; shadow_v[d_a] = 1; end
            else dma_q.push_back('{due: cyc + 1, data: shadow_rd(d_a)});
        end else begin
            chk("mem_idle_zero", {mem_we, mem_addr, mem_wdata}, 0);
        end
        if (resetn && cpu_req && !cpu_gnt) dut_wait++;
        else dut_wait = 0;
        chk("cpu_wait_bound", dut_wait <= MAX, 1);
        if (!resetn) begin
            dma_had = 0; cpu_waited = 0;
        end else begin
            cpu_waited = (c_pend && ed) ? cpu_waited + 1 : 0;
            dma_had = ed;
        end
        if (ec) c_pend = 0;
        if (ed) d_pend = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        gen();
        resetn = rst_drv;
        cpu_req = c_pend; cpu_we = c_w; cpu_addr = c_a; cpu_wdata = c_wd;
        dma_req = d_pend; dma_we = d_w; dma_addr = d_a; dma_wdata = d_wd;
        @(negedge clk);
        check_cycle();
    endtask

    // Read-return monitor: pops the scoreboard whenever a read is due
    always @(negedge clk) begin
        if (!resetn) begin
            if (cpu_rvalid) chk("cpu_rvalid_in_reset", cpu_rvalid, 0);
            if (dma_rvalid) chk("dma_rvalid_in_reset", dma_rvalid, 0);
            while (cpu_q.size() > 0 && cpu_q[0].due <= cyc) void'(cpu_q.pop_front());
            while (dma_q.size() > 0 && dma_q[0].due <= cyc) void'(dma_q.pop_front());
        end else begin
            if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
                chk("cpu_rvalid", cpu_rvalid, 1);
                chk("cpu_rdata", rdata, cpu_q[0].data);
                void'(cpu_q.pop_front());
            end else if (cpu_rvalid) begin
                chk("cpu_rvalid_unexpected", cpu_rvalid, 0);
            end
            if (dma_q.size() > 0 && dma_q[0].due <= cyc) begin
                chk("dma_rvalid", dma_rvalid, 1);
                chk("dma_rdata", rdata, dma_q[0].data);
                void'(dma_q.pop_front());
            end else if (dma_rvalid) begin
                chk("dma_rvalid_unexpected", dma_rvalid, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // 1: reset with both requesting, then CPU wins first
        rst_drv = 0;
        c_pend = 1; c_w = 0; c_a = 16'h0010;
        d_pend = 1; d_w = 0; d_a = 16'h0020;
        repeat (2) step();
        chk("rst_no_cpu_gnt", cpu_gnt, 0);
        chk("rst_no_mem_en", mem_en, 0);
        rst_drv = 1;
        step();
        chk("release_cpu_first", cpu_gnt, 1);
        repeat (3) step();

        // 2: lone CPU read, data one cycle later
        c_pend = 1; c_w = 0; c_a = 16'h1234;
        step();
        chk("t2_same_cycle_gnt", cpu_gnt, 1);
        step();
        chk("t2_rvalid", cpu_rvalid, 1);
        chk("t2_rdata", rdata, 8'hA5);
        repeat (2) step();

        // 3: DMA burst of reads, CPU joins at burst cycle 3
        dma_stream = 1; stream_left = 20; stream_ptr = 16'h0200;
        repeat (3) step();
        c_pend = 1; c_w = 0; c_a = 16'h0300;
        n = 0;
        do begin step(); n++; end while (c_pend && n < 40);
        chk("t3_cpu_grant_after_burst", n, MAX + 1);
        step();
        chk("t3_dma_resumes", dma_gnt, 1);
        n = 0;
        while ((stream_left > 0 || d_pend) && n < 60) begin step(); n++; end
        dma_stream = 0;
        repeat (2) step();

        // 4: simultaneous requests from idle, CPU write wins
        c_pend = 1; c_w = 1; c_a = 16'h00FF; c_wd = 8'h42;
        d_pend = 1; d_w = 0; d_a = 16'h00FF;
        step();
        chk("t4_cpu_gnt", cpu_gnt, 1);
        chk("t4_dma_gnt", dma_gnt, 0);
        chk("t4_mem_we", mem_we, 1);
        chk("t4_mem_wdata", mem_wdata, 8'h42);
        repeat (3) step();

        // 5: alternating single-master reads each cycle
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin c_pend = 1; c_w = 0; c_a = 16'($urandom_range(0, 255)); end
            else begin d_pend = 1; d_w = 0; d_a = 16'($urandom_range(0, 255)); end
            step();
        end
        repeat (2) step();

        // 6: one-cycle reset during a DMA burst with a read in flight
        dma_stream = 1; stream_left = 10; stream_ptr = 16'h0400;
        repeat (4) step();
        c_pend = 1; c_w = 0; c_a = 16'h0005;
        rst_drv = 0;
        step();
        chk("t6_dma_rvalid_dropped", dma_rvalid, 0);
        rst_drv = 1;
        step();
        chk("t6_owner_idle_cpu_wins", cpu_gnt, 1);
        chk("t6_no_stale_rvalid", dma_rvalid, 0);
        n = 0;
        while ((stream_left > 0 || d_pend) && n < 60) begin step(); n++; end
        dma_stream = 0;

        // Randomized traffic with occasional resets
        cpu_pct = 50; dma_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            rst_drv = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_drv = 1; cpu_pct = 0; dma_pct = 0;
        n = 0;
        while ((c_pend || d_pend) && n < 40) begin step(); n++; end
        repeat (3) step();
        chk("cpu_scoreboard_drained", cpu_q.size(), 0);
        chk("dma_scoreboard_drained", dma_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
